fetch_queue: RTL and testbench

//  Prefetch buffer between instruction memory and the instruction register/decoder.

---
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Prefetch FIFO between instruction memory and decode; holds {pc, instr} pairs and drops them on redirect.
// Optional same-cycle fetch->decode path when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         fetch_valid,
  input  logic [BITS-1:0]              fetch_pc,
  input  logic [BITS-1:0]              fetch_data,
  output logic                         fetch_ready,
  output logic                         instr_valid,
  output logic [BITS-1:0]              instr,
  output logic [BITS-1:0]              instr_pc,
  input  logic                         instr_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [BITS-1:0] pc;
    logic [BITS-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               full, empty, bypass, direct, push, pop;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign fetch_ready = !full;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & fetch_valid & !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately never touches the array.
  assign direct      = bypass & instr_ready;
  assign push        = fetch_valid & fetch_ready & !flush & !direct;
  assign pop         = !empty & instr_ready & !flush;
  assign instr_valid = !empty | bypass;

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (bypass) begin
      instr    = fetch_data;
      instr_pc = fetch_pc;
    end else if (!empty) begin
      instr    = mem[rd_ptr].data;
      instr_pc = mem[rd_ptr].pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ && push) mem[wr_ptr] <= '{pc: fetch_pc, data: fetch_data};
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst_) assert (count <= CNT_W'(DEPTH)) else $error("fetch_queue count %0d exceeds depth", count);
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed + randomized bench for fetch_queue, checked against a queue-based reference model.
module tb_fetch_queue;
  localparam int BITS  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_ = 1'b1;
  logic              fetch_valid = 1'b0;
  logic [BITS-1:0]   fetch_pc = '0, fetch_data = '0;
  logic              fetch_ready, instr_valid, instr_ready = 1'b0, flush = 1'b0;
  logic [BITS-1:0]   instr, instr_pc;
  logic [CNT_W-1:0]  count;

  int vectors = 0, miscompares = 0;

  typedef struct { logic [BITS-1:0] pc; logic [BITS-1:0] data; } ent_t;
  ent_t q[$];

  fetch_queue #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_(rst_), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_data(fetch_data), .fetch_ready(fetch_ready), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .flush(flush),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational view, then advance the model at posedge.
  task automatic cyc(input logic fv, input logic [BITS-1:0] pc, input logic [BITS-1:0] data,
                     input logic ir, input logic fl, input logic r, input bit check);
    bit byp, pop_e, acc;
    fetch_valid = fv; fetch_pc = pc; fetch_data = data;
    instr_ready = ir; flush = fl; rst_ = r;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (q.size() == 0) && fv && !fl;
`else
    byp = 1'b0;
`endif
    #1;
    if (check) begin
      chk("count",       64'(count),       64'(q.size()));
      chk("fetch_ready", 64'(fetch_ready), 64'(q.size() < DEPTH));
      chk("instr_valid", 64'(instr_valid), 64'((q.size() != 0) || byp));
      chk("instr",       64'(instr),       byp ? 64'(data) : (q.size() != 0 ? 64'(q[0].data) : 64'd0));
      chk("instr_pc",    64'(instr_pc),    byp ? 64'(pc)   : (q.size() != 0 ? 64'(q[0].pc)   : 64'd0));
    end
    @(posedge clk);
    if (r || fl) q.delete();
    else begin
      pop_e = (q.size() != 0) && ir;
      acc   = fv && (q.size() < DEPTH) && !(byp && ir);
      if (pop_e) void'(q.pop_front());
      if (acc) q.push_back('{pc: pc, data: data});
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // reset held two cycles with a word offered
    cyc(1, 32'h10, 32'h55, 0, 0, 1, 0);
    cyc(1, 32'h10, 32'h55, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_ready", 64'(fetch_ready), 64'd1);

    // fill to full, 5th push refused, then drain in order
    for (int i = 0; i < 5; i++) cyc(1, 32'(i), 32'hA0 + 32'(i), 0, 0, 0, 1);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(fetch_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_data", 64'(instr), 64'hA0 + 64'(i));
      cyc(0, 0, 0, 1, 0, 0, 1);
    end
    cyc(0, 0, 0, 1, 0, 0, 1);

    // wrap: 10 pushes interleaved with random pops
    for (int n = 0, guard = 0; n < 10 && guard < 200; guard++) begin
      logic fv = 1'($urandom);
      if (fv && count < DEPTH) n++;
      cyc(fv, 32'h100 + 32'(n), 32'hC000 + 32'(n), 1'($urandom), 0, 0, 1);
    end
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0, 1);

    // flush with 3 entries, same-cycle push and pop discarded
    for (int i = 0; i < 3; i++) cyc(1, 32'h20 + 32'(i), 32'hE0 + 32'(i), 0, 0, 0, 1);
    cyc(1, 32'h30, 32'hBB, 1, 1, 0, 1);
    chk("flush_count", 64'(count), 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h40, 32'hCC, 0, 0, 0, 1);
    chk("post_flush", 64'(instr), 64'hCC);
    cyc(0, 0, 0, 1, 0, 0, 1);

    // simultaneous push/pop at count=2
    cyc(1, 32'h50, 32'h11, 0, 0, 0, 1);
    cyc(1, 32'h51, 32'h22, 0, 0, 0, 1);
    cyc(1, 32'h52, 32'h33, 1, 0, 0, 1);
    chk("simul_count", 64'(count), 64'd2);
    chk("simul_head",  64'(instr), 64'h22);
    cyc(0, 0, 0, 0, 1, 0, 1);

    // empty with decode ready: bypass or one-cycle latency depending on build
    cyc(1, 32'h60, 32'hDD, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("nobyp_next", 64'(instr), 64'hDD);
`endif
    cyc(0, 0, 0, 1, 0, 0, 1);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom), $urandom, $urandom, 1'($urandom),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
